generatore_potenze: RTL and testbench
=====================================

# generatore_potenze

Sequential power-of-two word generator, the producer end of the power-of-two detector interface. On a start command it emits the words 2^lo … 2^hi (ascending) or 2^hi … 2^lo (descending), one per accepted transfer, over a valid/ready handshake. It then signals completion. It drives the detector's 8-bit input in self-checking benches and feeds one-hot masks to datapath blocks.

## Interface
- N, 8, output word width; must be a power of two, N ≥ 2.
- EW, 3, exponent width; must satisfy 2^EW == N.
- clock  input  1  sole clock; all state changes on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- start  input  1  command strobe; sampled only in IDLE.
- lo  input  EW  lowest exponent of the run; sampled with start.
- hi  input  EW  highest exponent of the run; sampled with start.
- dir  input  1  0 = ascending lo→hi, 1 = descending hi→lo; sampled with start.
- ready  input  1  consumer accepts x this cycle.
- x  output  N  declared [0:N-1] (bit 0 is the MSB); numeric value 2^e, exactly one bit set while valid; all zeros otherwise.
- valid  output  1  x holds a word of the run.
- busy  output  1  a run is in progress (RUN or DONE state).
- done  output  1  one-cycle pulse after the last word is accepted.
- err  output  1  one-cycle pulse when start is issued with lo > hi.

## Operation
- All outputs are registered; none is a combinational function of the inputs.
- The state machine has three states: IDLE, RUN and DONE. Internal registers hold the current exponent e (EW bits) and the latched lo, hi and dir.
- IDLE:
  - Outputs: valid=0, busy=0, x=0.
  - start=1 with lo ≤ hi: latch lo, hi and dir. Set e=lo (dir=0) or e=hi (dir=1). Go to RUN.
  - start=1 with lo > hi: err=1 for the next cycle only. Stay in IDLE.
- RUN:
  - Outputs: valid=1, busy=1, x = 2^e (numerically, bit x[N-1-e] set).
  - Transfer occurs on an edge with valid & ready.
  - On transfer with e not at the end of the run: e becomes e+1 (dir=0) or e-1 (dir=1), and x updates on the same edge.
  - On transfer with e at the end of the run (hi for dir=0, lo for dir=1): go to DONE. valid and x clear.
  - With ready=0, x and valid hold unchanged indefinitely.
- DONE: done=1, busy=1, valid=0 for exactly one cycle, then IDLE.
- start is ignored outside IDLE, and so are changes to lo, hi and dir during a run.
- lo == hi gives a single-word run.
- e never wraps: the end-of-run check precedes any increment or decrement. lo=0, hi=N-1 emits N words with no overflow.
- Reset (reset_n=0 at an edge), in any state including mid-run or while stalled: next state IDLE, x=0, valid=0, busy=0, done=0, err=0, e=0. The interrupted run is discarded, with no done pulse.

## Timing
- Start latency: start sampled at edge k ⇒ valid=1 with the first word from edge k+1.
- Throughput: with ready held at 1, one word per cycle. A run of M=hi-lo+1 words has valid high for M cycles and done high in cycle M+1 after that. IDLE is re-entered on the following edge.
- A new start is accepted at the earliest one cycle after done, i.e. in the first IDLE cycle.
- The err pulse appears one cycle after the offending start. busy stays 0 throughout.
- Each stall cycle (ready=0) extends the run by exactly one cycle.

## Test plan
- Full ascending run: reset, then start with lo=0, hi=7, dir=0, ready=1 ⇒ x = 01,02,04,08,10,20,40,80 (hex) on 8 consecutive valid cycles. done=1 in the 9th cycle, busy=0 in the 10th.
- Descending with stalls: lo=2, hi=5, dir=1, with ready toggling 1,0,1,0… ⇒ x sequence 20,10,08,04. Each value is held through its ready=0 cycle; done follows the last accepted 04.
- Single word and illegal command: lo=hi=3 ⇒ one word x=08, then done. Then lo=6, hi=1 ⇒ err=1 for one cycle, valid never asserts, busy=0.
- Start while busy: during a run lo=0, hi=3, pulse start with lo=5, hi=7 ⇒ ignored; the sequence stays 01,02,04,08.
- Reset mid-run: run lo=0, hi=7, and assert reset_n=0 while x=08 and ready=0 ⇒ next cycle all outputs are 0 and the state is IDLE. No done pulse. A fresh start then begins again at its own lo.
- Cross-check: feed x into the power-of-two detector ⇒ detector output 1 on every valid cycle.

Source files
------------

// File: rtl/generatore_potenze.sv
// Power-of-two word generator: on a start command it streams 2^lo..2^hi
// (ascending) or 2^hi..2^lo (descending) over a valid/ready handshake,
// then pulses done. An inverted range (lo > hi) produces a one-cycle err
// pulse instead of a run. All outputs are registered.
module generatore_potenze #(
    parameter int N  = 8,
    parameter int EW = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [EW-1:0] lo,
    input  logic [EW-1:0] hi,
    input  logic          dir,
    input  logic          ready,
    output logic [0:N-1]  x,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [EW-1:0] e_reg, e_next;
    logic [EW-1:0] lo_reg, lo_next;
    logic [EW-1:0] hi_reg, hi_next;
    logic          dir_reg, dir_next;

    logic [N-1:0]  x_reg, x_next;
    logic          valid_reg, valid_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;

    // One-hot decode of the next exponent; bit gi is the numeric weight 2^gi.
    logic [N-1:0]  e_onehot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_decode
            assign e_onehot[gi] = (e_next == EW'(gi));
        end
    endgenerate

    // The word is only shown while the next cycle carries a valid transfer.
    assign x_next = valid_next ? e_onehot : '0;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            e_reg     <= '0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            dir_reg   <= 1'b0;
            x_reg     <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            e_reg     <= e_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            dir_reg   <= dir_next;
            x_reg     <= x_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_next = state_reg;
        e_next     = e_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        dir_next   = dir_reg;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (lo <= hi) begin
                        lo_next    = lo;
                        hi_next    = hi;
                        dir_next   = dir;
                        e_next     = dir ? hi : lo;
                        state_next = RUN;
                        valid_next = 1'b1;
                        busy_next  = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RUN: begin
                busy_next  = 1'b1;
                valid_next = 1'b1;
                if (ready) begin
                    // End-of-run test comes first so e never wraps.
                    if (e_reg == (dir_reg ? lo_reg : hi_reg)) begin
                        state_next = DONE;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                    end else if (dir_reg) begin
                        e_next = e_reg - 1'b1;
                    end else begin
                        e_next = e_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign x     = x_reg;
    assign valid = valid_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_generatore_potenze.sv
// Directed bench for generatore_potenze: full runs, stalls, single-word and
// illegal commands, start while busy and reset in the middle of a run.
module tb_generatore_potenze;

    localparam int N  = 8;
    localparam int EW = 3;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [EW-1:0] lo;
    logic [EW-1:0] hi;
    logic          dir;
    logic          ready;
    logic [0:N-1]  x;
    logic          valid;
    logic          busy;
    logic          done;
    logic          err;

    int compared = 0;
    int failed   = 0;

    generatore_potenze #(.N(N), .EW(EW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .lo      (lo),
        .hi      (hi),
        .dir     (dir),
        .ready   (ready),
        .x       (x),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot against expected values.
    task automatic check_all(input string tag, input logic [7:0] ex, input logic ev,
                             input logic eb, input logic ed, input logic ee);
        logic [7:0] xv;
        xv = x;
        check({tag, ".x"}, 32'(xv), 32'(ex));
        check({tag, ".valid"}, 32'(valid), 32'(ev));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(ed));
        check({tag, ".err"}, 32'(err), 32'(ee));
        // Power-of-two detector cross-check: one bit set exactly when valid.
        check({tag, ".pow2"}, 32'($countones(xv) == 1), 32'(ev));
        $display("step %-10s x=%02h valid=%0b busy=%0b done=%0b err=%0b",
                 tag, xv, valid, busy, done, err);
    endtask

    task automatic issue(input logic [EW-1:0] l, input logic [EW-1:0] h, input logic d);
        lo    = l;
        hi    = h;
        dir   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] asc [8];
        logic [7:0] desc[4];
        asc  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        desc = '{8'h20, 8'h10, 8'h08, 8'h04};

        reset_n = 1'b0;
        start   = 1'b0;
        lo      = '0;
        hi      = '0;
        dir     = 1'b0;
        ready   = 1'b1;
        tick();
        tick();
        check_all("reset", 8'h00, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();

        // Full ascending run 0..7 with ready held high.
        issue(3'd0, 3'd7, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_all($sformatf("asc%0d", i), asc[i], 1, 1, 0, 0);
            tick();
        end
        check_all("asc_done", 8'h00, 0, 1, 1, 0);
        tick();
        check_all("asc_idle", 8'h00, 0, 0, 0, 0);

        // Descending 5..2 with a stall before each acceptance.
        issue(3'd2, 3'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_all($sformatf("dsc%0d", i), desc[i], 1, 1, 0, 0);
            ready = 1'b0;
            tick();
            check_all($sformatf("dsc%0d_hold", i), desc[i], 1, 1, 0, 0);
            ready = 1'b1;
            tick();
        end
        check_all("dsc_done", 8'h00, 0, 1, 1, 0);
        tick();
        check_all("dsc_idle", 8'h00, 0, 0, 0, 0);

        // Single-word run lo == hi == 3.
        issue(3'd3, 3'd3, 1'b0);
        check_all("single", 8'h08, 1, 1, 0, 0);
        tick();
        check_all("single_dn", 8'h00, 0, 1, 1, 0);
        tick();

        // Illegal range: err pulse only, no run.
        issue(3'd6, 3'd1, 1'b0);
        check_all("err", 8'h00, 0, 0, 0, 1);
        tick();
        check_all("err_clr", 8'h00, 0, 0, 0, 0);
        tick();
        check_all("err_idle", 8'h00, 0, 0, 0, 0);

        // Start while busy is ignored.
        issue(3'd0, 3'd3, 1'b0);
        check_all("busy0", 8'h01, 1, 1, 0, 0);
        tick();
        check_all("busy1", 8'h02, 1, 1, 0, 0);
        lo    = 3'd5;
        hi    = 3'd7;
        dir   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_all("busy2", 8'h04, 1, 1, 0, 0);
        tick();
        check_all("busy3", 8'h08, 1, 1, 0, 0);
        tick();
        check_all("busy_dn", 8'h00, 0, 1, 1, 0);
        tick();
        check_all("busy_idle", 8'h00, 0, 0, 0, 0);

        // Reset in the middle of a stalled run.
        issue(3'd0, 3'd7, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check_all("rst_pre", 8'h08, 1, 1, 0, 0);
        ready = 1'b0;
        tick();
        check_all("rst_stall", 8'h08, 1, 1, 0, 0);
        reset_n = 1'b0;
        tick();
        check_all("rst_hit", 8'h00, 0, 0, 0, 0);
        reset_n = 1'b1;
        ready   = 1'b1;
        tick();
        check_all("rst_after", 8'h00, 0, 0, 0, 0);

        // Fresh run after reset begins at its own lo.
        issue(3'd4, 3'd5, 1'b0);
        check_all("fresh0", 8'h10, 1, 1, 0, 0);
        tick();
        check_all("fresh1", 8'h20, 1, 1, 0, 0);
        tick();
        check_all("fresh_dn", 8'h00, 0, 1, 1, 0);
        tick();
        check_all("fresh_idle", 8'h00, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
